// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with one-word frames.
// Hits are answered combinationally in IDLE. A miss latches the word
// address and refills that frame from memory through a single-word
// iREN/iwait handshake, then returns to IDLE so the access can hit.
module icache #(
  parameter int NFRAMES = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int IW = $clog2(NFRAMES);
  localparam int TW = 30 - IW;

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

  state_t              r_state;
  state_t              w_next_state;

  logic [NFRAMES-1:0]  r_valid;
  logic [TW-1:0]       r_tag  [NFRAMES];
  logic [31:0]         r_data [NFRAMES];
  logic [31:0]         r_miss_addr;
  logic [31:0]         r_hit_count;
  logic [31:0]         r_miss_count;

  logic [IW-1:0]       w_idx;
  logic [TW-1:0]       w_tag;
  logic [IW-1:0]       w_fill_idx;
  logic [TW-1:0]       w_fill_tag;
  logic                w_hit;
  logic                w_miss;
  logic                w_fill;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign w_idx      = imemaddr[IW+1:2];
  assign w_tag      = imemaddr[31:IW+2];
  assign w_fill_idx = r_miss_addr[IW+1:2];
  assign w_fill_tag = r_miss_addr[31:IW+2];

  // Lookups only count in IDLE; during a refill the datapath always sees a miss.
  assign w_hit  = (r_state == IDLE) && imemREN && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_miss = (r_state == IDLE) && imemREN && !w_hit;
  assign w_fill = (r_state == FETCH) && !iwait;

  // State register; reset abandons any refill in progress.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next state: a miss starts a refill, the first non-wait cycle ends it.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_miss) w_next_state = FETCH;
      FETCH:   if (!iwait) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Outputs: refill request decoded from state only, so it is stable for the whole FETCH.
  always_comb begin
    ihit       = w_hit;
    imemload   = w_hit ? r_data[w_idx] : 32'd0;
    iREN       = (r_state == FETCH);
    iaddr      = (r_state == FETCH) ? r_miss_addr : 32'd0;
    hit_count  = r_hit_count;
    miss_count = r_miss_count;
  end

  // Miss address is captured once, so a redirect during FETCH cannot retarget the refill.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)       r_miss_addr <= 32'd0;
    else if (w_miss) r_miss_addr <= {imemaddr[31:2], 2'b00};
  end

  // Valid bits: cleared on reset, set when a refill completes.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)       r_valid <= '0;
    else if (w_fill) r_valid[w_fill_idx] <= 1'b1;
  end

  // Tag and data arrays carry no reset; valid bits guard them.
  always_ff @(posedge CLK) begin
    if (w_fill) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= iload;
    end
  end

  // Hit and completed-refill statistics.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_hit_count  <= 32'd0;
      r_miss_count <= 32'd0;
    end else begin
      if (w_hit)  r_hit_count  <= sat_inc(r_hit_count);
      if (w_fill) r_miss_count <= sat_inc(r_miss_count);
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: reset, first fill, hit reuse, conflict
// eviction, redirect during refill, reset during refill, and idle lookups.
module tb_icache;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int passed;
  int total;

  icache #(.NFRAMES(16)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .imemREN   (imemREN),
    .imemaddr  (imemaddr),
    .ihit      (ihit),
    .imemload  (imemload),
    .iREN      (iREN),
    .iaddr     (iaddr),
    .iwait     (iwait),
    .iload     (iload),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Miss on addr, hold iwait high for nwait FETCH cycles, then return data.
  // Ends in IDLE with the access still presented (it will now hit).
  task automatic fill(input logic [31:0] addr, input logic [31:0] data, input int nwait);
    imemREN  = 1'b1;
    imemaddr = addr;
    iwait    = 1'b1;
    step();
    for (int k = 0; k < nwait; k++) step();
    iwait = 1'b0;
    iload = data;
    step();
    iwait = 1'b1;
    iload = 32'd0;
  endtask

  task automatic test_reset();
    nRST = 1'b0; imemREN = 1'b1; imemaddr = 32'd0; iwait = 1'b1; iload = 32'd0;
    #2;
    total++; if (iREN !== 1'b0) $display("FAIL rst_iREN: got %b want 0", iREN); else passed++;
    total++; if (iaddr !== 32'd0) $display("FAIL rst_iaddr: got %h want 0", iaddr); else passed++;
    total++; if (ihit !== 1'b0) $display("FAIL rst_ihit: got %b want 0", ihit); else passed++;
    total++; if (imemload !== 32'd0) $display("FAIL rst_imemload: got %h want 0", imemload); else passed++;
    total++; if (hit_count !== 32'd0) $display("FAIL rst_hit_count: got %0d want 0", hit_count); else passed++;
    total++; if (miss_count !== 32'd0) $display("FAIL rst_miss_count: got %0d want 0", miss_count); else passed++;
    step(); step();
    total++; if (iREN !== 1'b0 || ihit !== 1'b0) $display("FAIL rst_held: iREN=%b ihit=%b want 0 0", iREN, ihit); else passed++;
    nRST = 1'b1;
  endtask

  // Cycle 0 is the current IDLE cycle with 0x0 presented; two wait cycles.
  task automatic test_first_fill();
    #1;
    total++; if (ihit !== 1'b0 || iREN !== 1'b0) $display("FAIL ff_c0: ihit=%b iREN=%b want 0 0", ihit, iREN); else passed++;
    for (int c = 1; c <= 3; c++) begin
      step();
      if (c == 3) begin iwait = 1'b0; iload = 32'h8C01_0004; end
      #1;
      total++; if (iREN !== 1'b1) $display("FAIL ff_iREN_c%0d: got %b want 1", c, iREN); else passed++;
      total++; if (iaddr !== 32'd0) $display("FAIL ff_iaddr_c%0d: got %h want 0", c, iaddr); else passed++;
      total++; if (ihit !== 1'b0) $display("FAIL ff_ihit_c%0d: got %b want 0", c, ihit); else passed++;
    end
    step();
    iwait = 1'b1; iload = 32'd0;
    #1;
    total++; if (ihit !== 1'b1) $display("FAIL ff_c4_ihit: got %b want 1", ihit); else passed++;
    total++; if (imemload !== 32'h8C01_0004) $display("FAIL ff_c4_data: got %h want 8c010004", imemload); else passed++;
    total++; if (iREN !== 1'b0) $display("FAIL ff_c4_iREN: got %b want 0", iREN); else passed++;
    total++; if (miss_count !== 32'd1) $display("FAIL ff_miss_count: got %0d want 1", miss_count); else passed++;
  endtask

  task automatic test_hit_reuse();
    for (int c = 0; c < 5; c++) begin
      total++; if (ihit !== 1'b1) $display("FAIL reuse_ihit_%0d: got %b want 1", c, ihit); else passed++;
      total++; if (imemload !== 32'h8C01_0004) $display("FAIL reuse_data_%0d: got %h want 8c010004", c, imemload); else passed++;
      total++; if (iREN !== 1'b0) $display("FAIL reuse_iREN_%0d: got %b want 0", c, iREN); else passed++;
      step();
    end
    total++; if (hit_count !== 32'd5) $display("FAIL reuse_hit_count: got %0d want 5", hit_count); else passed++;
    total++; if (miss_count !== 32'd1) $display("FAIL reuse_miss_count: got %0d want 1", miss_count); else passed++;
    imemREN = 1'b0;
  endtask

  task automatic test_conflict();
    imemREN = 1'b0;
    nRST = 1'b0;
    step();
    nRST = 1'b1;
    fill(32'h00, 32'hAAAA_AAAA, 1);
    fill(32'h40, 32'hBBBB_BBBB, 0);
    #1;
    total++; if (ihit !== 1'b1 || imemload !== 32'hBBBB_BBBB) $display("FAIL cf_hit40: ihit=%b data=%h want 1 bbbbbbbb", ihit, imemload); else passed++;
    imemaddr = 32'h00;
    #1;
    total++; if (ihit !== 1'b0) $display("FAIL cf_evicted00: ihit=%b want 0", ihit); else passed++;
    fill(32'h00, 32'hAAAA_AAAA, 2);
    #1;
    total++; if (ihit !== 1'b1 || imemload !== 32'hAAAA_AAAA) $display("FAIL cf_refill00: ihit=%b data=%h want 1 aaaaaaaa", ihit, imemload); else passed++;
    total++; if (miss_count !== 32'd3) $display("FAIL cf_miss_count: got %0d want 3", miss_count); else passed++;
    imemaddr = 32'h04;
    #1;
    total++; if (ihit !== 1'b0) $display("FAIL cf_frame1_untouched: ihit=%b want 0", ihit); else passed++;
    fill(32'h04, 32'hCCCC_CCCC, 0);
    #1;
    total++; if (ihit !== 1'b1 || imemload !== 32'hCCCC_CCCC) $display("FAIL cf_hit04: ihit=%b data=%h want 1 cccccccc", ihit, imemload); else passed++;
    imemaddr = 32'h00;
    #1;
    total++; if (ihit !== 1'b1 || imemload !== 32'hAAAA_AAAA) $display("FAIL cf_keep00: ihit=%b data=%h want 1 aaaaaaaa", ihit, imemload); else passed++;
    imemREN = 1'b0;
  endtask

  task automatic test_redirect();
    imemREN = 1'b1; imemaddr = 32'h10; iwait = 1'b1;
    #1;
    total++; if (ihit !== 1'b0) $display("FAIL rd_miss10: ihit=%b want 0", ihit); else passed++;
    step();
    imemaddr = 32'h20;
    #1;
    total++; if (iREN !== 1'b1 || iaddr !== 32'h10) $display("FAIL rd_c1: iREN=%b iaddr=%h want 1 00000010", iREN, iaddr); else passed++;
    total++; if (ihit !== 1'b0) $display("FAIL rd_c1_ihit: got %b want 0", ihit); else passed++;
    step();
    iwait = 1'b0; iload = 32'h1010_1010;
    #1;
    total++; if (iREN !== 1'b1 || iaddr !== 32'h10) $display("FAIL rd_c2: iREN=%b iaddr=%h want 1 00000010", iREN, iaddr); else passed++;
    step();
    iwait = 1'b1; iload = 32'd0;
    #1;
    total++; if (iREN !== 1'b0 || ihit !== 1'b0) $display("FAIL rd_c3_idle_miss20: iREN=%b ihit=%b want 0 0", iREN, ihit); else passed++;
    step();
    #1;
    total++; if (iREN !== 1'b1 || iaddr !== 32'h20) $display("FAIL rd_c4: iREN=%b iaddr=%h want 1 00000020", iREN, iaddr); else passed++;
    iwait = 1'b0; iload = 32'h2020_2020;
    step();
    iwait = 1'b1; iload = 32'd0;
    #1;
    total++; if (ihit !== 1'b1 || imemload !== 32'h2020_2020) $display("FAIL rd_hit20: ihit=%b data=%h want 1 20202020", ihit, imemload); else passed++;
    total++; if (miss_count !== 32'd6) $display("FAIL rd_miss_count: got %0d want 6", miss_count); else passed++;
    imemaddr = 32'h10;
    #1;
    total++; if (ihit !== 1'b1 || imemload !== 32'h1010_1010) $display("FAIL rd_hit10: ihit=%b data=%h want 1 10101010", ihit, imemload); else passed++;
    imemREN = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    imemREN = 1'b1; imemaddr = 32'h30; iwait = 1'b1;
    step();
    #1;
    total++; if (iREN !== 1'b1) $display("FAIL rmf_fetching: iREN=%b want 1", iREN); else passed++;
    imemREN = 1'b0;
    nRST = 1'b0;
    #1;
    total++; if (iREN !== 1'b0 || iaddr !== 32'd0) $display("FAIL rmf_iREN: iREN=%b iaddr=%h want 0 0", iREN, iaddr); else passed++;
    total++; if (hit_count !== 32'd0 || miss_count !== 32'd0) $display("FAIL rmf_counts: hit=%0d miss=%0d want 0 0", hit_count, miss_count); else passed++;
    total++; if (ihit !== 1'b0 || imemload !== 32'd0) $display("FAIL rmf_ihit: ihit=%b data=%h want 0 0", ihit, imemload); else passed++;
    step();
    nRST = 1'b1;
    imemREN = 1'b1; imemaddr = 32'h00;
    #1;
    total++; if (ihit !== 1'b0) $display("FAIL rmf_00_misses: ihit=%b want 0", ihit); else passed++;
    imemREN = 1'b0;
  endtask

  task automatic test_ren_low();
    fill(32'h00, 32'h0BAD_F00D, 1);
    #1;
    total++; if (ihit !== 1'b1 || imemload !== 32'h0BAD_F00D) $display("FAIL rl_filled: ihit=%b data=%h want 1 0badf00d", ihit, imemload); else passed++;
    imemREN = 1'b0;
    #1;
    total++; if (ihit !== 1'b0 || imemload !== 32'd0) $display("FAIL rl_ihit: ihit=%b data=%h want 0 0", ihit, imemload); else passed++;
    for (int c = 0; c < 3; c++) begin
      step();
      total++; if (ihit !== 1'b0 || iREN !== 1'b0) $display("FAIL rl_idle_%0d: ihit=%b iREN=%b want 0 0", c, ihit, iREN); else passed++;
    end
    total++; if (hit_count !== 32'd0 || miss_count !== 32'd1) $display("FAIL rl_counts: hit=%0d miss=%0d want 0 1", hit_count, miss_count); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_first_fill();
    test_hit_reuse();
    test_conflict();
    test_redirect();
    test_reset_mid_fetch();
    test_ren_low();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache that answers the pipelined datapath's instruction-fetch requests on the datapath side of `datapath_cache_if` (`imemREN`/`imemaddr` in; `ihit`/`imemload` out). It refills missing frames from the memory controller with a single-word read handshake (`iREN`/`iaddr` out; `iwait`/`iload` in). It sits between the datapath's IF stage and the memory arbiter, one instance per core.

## Interface
- `NFRAMES`, 16: number of one-word frames; power of two, 2..256. `IW = $clog2(NFRAMES)`.
- `CLK` in 1: clock, rising edge.
- `nRST` in 1: reset, asynchronous, active-low.
- `imemREN` in 1: datapath requests an instruction this cycle.
- `imemaddr` in 32: byte address of the instruction; bits [1:0] are ignored.
- `ihit` out 1: `imemload` is valid for `imemaddr` this cycle.
- `imemload` out 32: instruction word; 0 when `ihit`=0.
- `iREN` out 1: refill read request to the memory controller.
- `iaddr` out 32: refill word address, with [1:0]=00.
- `iwait` in 1: memory busy; `iload` is valid in any `iREN` cycle where `iwait`=0.
- `iload` in 32: refill data.
- `hit_count` out 32: number of hits since reset; saturates at 0xFFFFFFFF.
- `miss_count` out 32: number of refills completed since reset; saturates.

## Operation
- Address split: index = `imemaddr[IW+1:2]`, tag = `imemaddr[31:IW+2]`.
- Each frame holds a valid bit, a tag of 30-IW bits, and a 32-bit data word.
- State machine, 2 states: IDLE, FETCH.
- IDLE:
  - Hit condition: `imemREN` & valid[index] & tag match. On a hit, `ihit`=1 and `imemload`=data[index], both combinational. `hit_count` increments at the edge.
  - On a miss (`imemREN` & no hit), latch `{imemaddr[31:2],2'b00}` into `miss_addr` and go to FETCH. `ihit`=0.
  - When `imemREN`=0, `ihit`=0, the state stays IDLE, and no counter changes.
- FETCH:
  - Drive `iREN`=1 and `iaddr`=`miss_addr`, both registered from state, so they are stable for the whole FETCH.
  - `ihit`=0 regardless of `imemaddr`.
  - When `iwait`=0: write frame[`miss_addr` index] with valid=1, tag, and `iload`. Increment `miss_count` and return to IDLE.
  - When `iwait`=1: stay in FETCH.
- Address change during FETCH (branch/jump redirect): the refill for `miss_addr` completes unchanged. The new `imemaddr` is evaluated in IDLE afterwards and may miss again.
- A refill overwrites whatever frame occupied the index (conflict eviction). There is no write path from the datapath; `dmem*` traffic is not handled here.
- Counters hold at 0xFFFFFFFF.
- Reset, including asserting `nRST` mid-FETCH:
  - All valid bits cleared.
  - State goes to IDLE; `miss_addr`=0.
  - `iREN`=0, `iaddr`=0, `hit_count`=0, `miss_count`=0.
  - `ihit`=0 and `imemload`=0 while in reset.
  - An aborted refill writes nothing. Tag and data arrays need no reset.

## Timing
- Hit: zero-cycle latency; `ihit` and `imemload` follow `imemaddr` combinationally in IDLE.
- Miss with N wait cycles (`iwait`=1 for N FETCH cycles):
  - Cycle 0: miss detected in IDLE.
  - Cycles 1..N+1: FETCH, with `iREN`=1.
  - Cycle N+1 has `iwait`=0 and writes the frame.
  - Cycle N+2: IDLE hit with `ihit`=1.
  - Total miss penalty is N+2 cycles. No bypass of `iload` to `imemload`.
- `iREN` deasserts on the edge after the `iwait`=0 cycle; it is never high in IDLE.
- Back-to-back misses: at least one IDLE cycle separates consecutive FETCH bursts.
- `imemREN` dropping during FETCH does not cancel the refill.

## Test plan
- Reset, then `imemREN`=1 at 0x00000000, memory returns 0x8C010004 after 2 `iwait` cycles:
  - `ihit`=0 until cycle 4.
  - Then `ihit`=1 with `imemload`=0x8C010004.
  - `iREN` is high exactly cycles 1-3 with `iaddr`=0x0.
  - `miss_count`=1.
- Hit reuse: after the fill above, hold 0x0 for 5 cycles. Required: `ihit`=1 every cycle, `iREN` never asserts, `hit_count` increases by 5.
- Conflict eviction (`NFRAMES`=16):
  - Fill 0x00 with 0xAAAAAAAA, then access 0x40 and fill it with 0xBBBBBBBB.
  - Re-access 0x00: it misses and refills (`miss_count`=3).
  - 0x04 is unaffected.
- Redirect mid-miss:
  - Miss on 0x10, then change `imemaddr` to 0x20 while `iwait`=1.
  - Required: `iaddr` stays 0x10, frame 4 is filled, then a second FETCH runs with `iaddr`=0x20.
  - 0x10 later hits.
- Reset mid-FETCH:
  - Assert `nRST` while `iREN`=1.
  - Required: `iREN`=0 immediately, both counters 0, and the previously filled 0x00 misses after reset.
- `imemREN`=0 with a valid frame at `imemaddr`: `ihit`=0, `imemload`=0, and both counters unchanged.
